// File: rtl/nibble_sum_acc_pkg.sv
// nibble_sum_acc_pkg
// Shared definitions for the nibble sum accumulator:
//   state_t - frame FSM states (ACCUM collects results, HOLD presents the total)
//   OPND_W  - width of one adder result, {carry, sum[3:0]}
package nibble_sum_acc_pkg;

    localparam int OPND_W = 5;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/nibble_sum_accumulator_acc_add.sv
// acc_add
// Combinational ACC_W-bit adder: accumulator plus a zero-extended 5-bit operand.
// Ports:
//   i_acc   [ACC_W-1:0]  current accumulator value
//   i_opnd  [OPND_W-1:0] adder result {carry, sum}
//   o_sum   [ACC_W-1:0]  low ACC_W bits of the sum
//   o_carry              carry out of the ACC_W-bit add
module acc_add
    import nibble_sum_acc_pkg::*;
#(
    parameter int ACC_W = 12
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [OPND_W-1:0] i_opnd,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_carry
);

    logic [ACC_W:0] w_full;

    always_comb begin
        w_full = {1'b0, i_acc} + {{(ACC_W + 1 - OPND_W){1'b0}}, i_opnd};
    end

    assign o_sum   = w_full[ACC_W-1:0];
    assign o_carry = w_full[ACC_W];

endmodule

// File: rtl/nibble_sum_accumulator.sv
// nibble_sum_accumulator
// Sums N_SAMPLES 5-bit adder results ({in_carry, in_sum}) per frame and
// presents the frame total on a valid/ready port, with a sticky overflow flag.
// Build option: define NIBBLE_SUM_ACC_SAT_EN to saturate the accumulator at
// 2^ACC_W-1 on overflow; otherwise it wraps modulo 2^ACC_W.
// Parameters: ACC_W (>= 5) accumulator width, N_SAMPLES (>= 1) results per frame.
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   in_valid / in_ready   upstream handshake; in_ready depends on state only
//   in_sum[3:0], in_carry adder result
//   clear                 synchronous frame abort, beats any handshake
//   out_valid / out_ready downstream handshake for the frame total
//   out_acc[ACC_W-1:0]    registered frame total
//   out_ovf               overflow seen during this frame
module nibble_sum_accumulator
    import nibble_sum_acc_pkg::*;
#(
    parameter int ACC_W     = 12,
    parameter int N_SAMPLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_sum,
    input  logic             in_carry,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);

    // One extra count value keeps N_SAMPLES=1 legal (1-bit counter).
    localparam int CNT_W = $clog2(N_SAMPLES + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    logic             w_accept;
    logic             w_out_hs;
    logic             w_last;
    logic [ACC_W-1:0] w_sum;
    logic             w_carry;
    logic [ACC_W-1:0] w_acc_nxt;

    // Handshakes are decoded from the registered state, not from the port
    // outputs, so no combinational path links out_ready to in_ready.
    assign w_accept = in_valid  & (r_state == ACCUM) & ~clear;
    assign w_out_hs = out_ready & (r_state == HOLD)  & ~clear;
    assign w_last   = (r_cnt == CNT_W'(N_SAMPLES - 1));

    acc_add #(
        .ACC_W (ACC_W)
    ) u_acc_add (
        .i_acc   (r_acc),
        .i_opnd  ({in_carry, in_sum}),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

`ifdef NIBBLE_SUM_ACC_SAT_EN
    // Once clamped at all-ones, any non-zero operand carries again and a zero
    // operand leaves it there, so the value stays pinned for the frame.
    assign w_acc_nxt = w_carry ? '1 : w_sum;
`else
    assign w_acc_nxt = w_sum;
`endif

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        unique case (r_state)
            ACCUM: begin
                in_ready = 1'b1;
                if (w_accept && w_last) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (w_out_hs) begin
                    w_state_nxt = ACCUM;
                end
            end
            default: w_state_nxt = ACCUM;
        endcase
        if (clear) begin
            w_state_nxt = ACCUM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (clear) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_out_hs) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_acc_nxt;
            r_ovf <= r_ovf | w_carry;
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign out_acc = r_acc;
    assign out_ovf = r_ovf;

endmodule

// File: tb/tb_nibble_sum_accumulator.sv
// Testbench for nibble_sum_accumulator. Two instances share the input stream:
// dut0 (ACC_W=6, N_SAMPLES=4) and dut1 (ACC_W=5, N_SAMPLES=1), each with its
// own out_ready. The reference model keeps a running integer total per frame
// and derives the expected wrap/saturate value from it.
module tb_nibble_sum_accumulator;

    localparam int AW0 = 6;
    localparam int NS0 = 4;
    localparam int AW1 = 5;
    localparam int NS1 = 1;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic [3:0]     in_sum;
    logic           in_carry;
    logic           clear;
    logic           out_ready0;
    logic           out_ready1;
    logic           in_ready0;
    logic           in_ready1;
    logic           out_valid0;
    logic           out_valid1;
    logic [AW0-1:0] out_acc0;
    logic [AW1-1:0] out_acc1;
    logic           out_ovf0;
    logic           out_ovf1;

    nibble_sum_accumulator #(.ACC_W(AW0), .N_SAMPLES(NS0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_sum(in_sum), .in_carry(in_carry), .clear(clear),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .out_acc(out_acc0), .out_ovf(out_ovf0)
    );

    nibble_sum_accumulator #(.ACC_W(AW1), .N_SAMPLES(NS1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_sum(in_sum), .in_carry(in_carry), .clear(clear),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_acc(out_acc1), .out_ovf(out_ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int acc;
        int ovf;
    } exp_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   aw[2] = '{AW0, AW1};
    int   ns[2] = '{NS0, NS1};
    int   tot[2];
    int   cnt[2];
    bit   pend[2];
    exp_t q0[$];
    exp_t q1[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_acc(input int k, input int total);
        int mx;
        mx = (1 << aw[k]) - 1;
        if (total > mx) begin
`ifdef NIBBLE_SUM_ACC_SAT_EN
            return mx;
`else
            return total % (mx + 1);
`endif
        end
        return total;
    endfunction

    function automatic int exp_ovf(input int k, input int total);
        return (total > (1 << aw[k]) - 1) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            tot[k]  = 0;
            cnt[k]  = 0;
            pend[k] = 1'b0;
        end
        q0.delete();
        q1.delete();
    endtask

    // What the coming clock edge does to instance k, given the driven inputs.
    task automatic model_edge(input int k, input bit iv, input int op,
                              input bit clr, input bit ordy);
        exp_t e;
        if (clr) begin
            if (pend[k]) begin
                if (k == 0) void'(q0.pop_back());
                else        void'(q1.pop_back());
            end
            tot[k] = 0; cnt[k] = 0; pend[k] = 1'b0;
        end else if (pend[k]) begin
            if (ordy) begin
                tot[k] = 0; pend[k] = 1'b0;
            end
        end else if (iv) begin
            tot[k] += op;
            cnt[k]++;
            if (cnt[k] == ns[k]) begin
                cnt[k]  = 0;
                pend[k] = 1'b1;
                e.acc   = exp_acc(k, tot[k]);
                e.ovf   = exp_ovf(k, tot[k]);
                if (k == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end
    endtask

    task automatic check_all();
        chk("in_ready0",  int'(in_ready0),  int'(!pend[0]));
        chk("out_valid0", int'(out_valid0), int'(pend[0]));
        chk("out_acc0",   int'(out_acc0),   exp_acc(0, tot[0]));
        chk("out_ovf0",   int'(out_ovf0),   exp_ovf(0, tot[0]));
        chk("in_ready1",  int'(in_ready1),  int'(!pend[1]));
        chk("out_valid1", int'(out_valid1), int'(pend[1]));
        chk("out_acc1",   int'(out_acc1),   exp_acc(1, tot[1]));
        chk("out_ovf1",   int'(out_ovf1),   exp_ovf(1, tot[1]));
    endtask

    task automatic step(input bit iv, input bit c, input logic [3:0] s,
                        input bit clr, input bit r0, input bit r1);
        in_valid   = iv;
        in_carry   = c;
        in_sum     = s;
        clear      = clr;
        out_ready0 = r0;
        out_ready1 = r1;
        model_edge(0, iv, int'({c, s}), clr, r0);
        model_edge(1, iv, int'({c, s}), clr, r1);
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Called 1 ns after a rising edge; asserts reset between edges.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        in_valid = 1'b1;
        in_carry = 1'b1;
        in_sum   = 4'hf;
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
    endtask

    // Scoreboard monitor: a frame total is consumed where the handshake fires.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && !clear) begin
            if (out_valid0 && out_ready0) begin
                if (q0.size() == 0) begin
                    chk("frame0 unexpected", 1, 0);
                end else begin
                    e = q0.pop_front();
                    chk("frame0 acc", int'(out_acc0), e.acc);
                    chk("frame0 ovf", int'(out_ovf0), e.ovf);
                end
            end
            if (out_valid1 && out_ready1) begin
                if (q1.size() == 0) begin
                    chk("frame1 unexpected", 1, 0);
                end else begin
                    e = q1.pop_front();
                    chk("frame1 acc", int'(out_acc1), e.acc);
                    chk("frame1 ovf", int'(out_ovf1), e.ovf);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_sum     = 4'h0;
        in_carry   = 1'b0;
        clear      = 1'b0;
        out_ready0 = 1'b0;
        out_ready1 = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Basic sum 3+5+7+18 = 33
        step(1, 0, 4'd3, 0, 0, 1);
        step(1, 0, 4'd5, 0, 0, 1);
        step(1, 0, 4'd7, 0, 0, 1);
        step(1, 1, 4'd2, 0, 0, 1);
        chk("basic out_acc", int'(out_acc0), 33);

        // Backpressure: total held, no accepts, then release
        for (int i = 0; i < 5; i++) step(1, 1, 4'hf, 0, 0, 1);
        step(1, 0, 4'd1, 0, 1, 1);
        step(1, 0, 4'd2, 0, 0, 1);

        // Overflow: four 31s = 124 into a 6-bit accumulator
        step(0, 0, 4'd0, 1, 1, 1);
        for (int i = 0; i < 4; i++) step(1, 1, 4'hf, 0, 0, 1);
        step(0, 0, 4'd0, 0, 1, 1);

        // Clear alongside a valid input, then a frame of ones
        step(1, 0, 4'd4, 0, 1, 1);
        step(1, 0, 4'd4, 0, 1, 1);
        step(1, 1, 4'hf, 1, 1, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 4'd1, 0, 1, 1);
        chk("clear frame out_acc", int'(out_acc0), 4);
        step(0, 0, 4'd0, 0, 1, 1);

        // Asynchronous reset mid-frame, then a fresh frame
        step(1, 0, 4'd9, 0, 1, 1);
        step(1, 0, 4'd9, 0, 1, 1);
        async_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 4'(i + 2), 0, 1, 1);
        step(0, 0, 4'd0, 0, 1, 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (i == 300) async_reset();
            step($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom),
                 $urandom_range(0, 31) == 0,
                 $urandom_range(0, 4) < 3, $urandom_range(0, 1) == 1);
        end

        for (int i = 0; i < 4; i++) step(0, 0, 4'd0, 0, 1, 1);
        chk("queue0 drained", q0.size(), 0);
        chk("queue1 drained", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nibble_sum_accumulator.md
# nibble_sum_accumulator

- Accumulates a stream of 5-bit results, each a 4-bit sum plus its carry-out, from the 4-bit ripple adder stage.
- Sits directly downstream of that adder.
- After every N_SAMPLES accepted results, presents the running total on a valid/ready output port, then restarts.
- Tracks overflow with a sticky flag.

## Interface
- ACC_W, default 12: accumulator width in bits; must be at least 5.
- N_SAMPLES, default 8: number of results per frame; must be at least 1.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  upstream result valid.
- in_ready  out  1  block accepts a result this cycle.
- in_sum  in  4  adder sum bits.
- in_carry  in  1  adder carry-out.
- clear  in  1  synchronous abort and restart of the frame.
- out_valid  out  1  frame total available.
- out_ready  in  1  downstream accepts the total.
- out_acc  out  ACC_W  frame total.
- out_ovf  out  1  overflow occurred during this frame.

## Operation
- Operand is {in_carry, in_sum}, zero-extended to ACC_W bits (range 0..31).
- An accept happens when in_valid and in_ready are both high on a clock edge.
- FSM has two states, ACCUM and HOLD.
- ACCUM:
  - in_ready=1, out_valid=0.
  - On accept: acc <= acc + operand, cnt <= cnt + 1.
  - If the accept is number N_SAMPLES (cnt == N_SAMPLES-1), go to HOLD and set cnt <= 0.
- HOLD:
  - in_ready=0, out_valid=1.
  - out_acc and out_ovf are held stable.
  - On out_valid & out_ready: acc <= 0, ovf <= 0, go to ACCUM.
- Overflow: the carry out of the ACC_W-bit add sets ovf, which is sticky until the frame is consumed.
- Wrap vs. saturate behaviour is set by the macro in Configuration.
- clear has top priority over any accept or handshake in the same cycle:
  - acc, cnt and ovf go to 0; state goes to ACCUM.
  - A pending total in HOLD is discarded.
  - An input presented in the same cycle is not accepted and not summed.
- Counter width is $clog2(N_SAMPLES+1), so N_SAMPLES=1 is legal: HOLD is entered after every accept.

## Timing
- Reset values: state=ACCUM, acc=0, cnt=0, ovf=0, out_valid=0, out_acc=0, out_ovf=0, in_ready=1.
- Inputs are ignored while rst is high.
- Reset mid-frame discards all partial state immediately (asynchronous).
- Latency: out_valid rises on the edge that performs the final accept. The total is visible in the cycle after the last input handshake.
- Throughput: one result per cycle in ACCUM.
- Frame turnaround: one cycle minimum. HOLD lasts at least one cycle, and the next accept is possible on the cycle after the output handshake.
- No combinational path from out_ready to in_ready: in_ready depends on state only.
- out_acc is registered, equal to acc.

## Configuration
- Macro: NIBBLE_SUM_ACC_SAT_EN.
- Defined: on overflow, acc clamps to 2^ACC_W-1 and stays there for the rest of the frame; ovf=1.
- Undefined: acc wraps modulo 2^ACC_W; ovf=1.

## Structure
- Package nibble_sum_acc_pkg holds:
  - state enum typedef (ACCUM, HOLD);
  - localparam OPND_W=5.
- One sub-module, acc_add: combinational ACC_W-bit adder of acc and the extended operand.
  - Outputs the sum and its carry-out.
  - Saturation muxing lives in the parent.
- FSM, counter and registers live in nibble_sum_accumulator.

## Test plan
- Basic sum (ACC_W=8, N_SAMPLES=4): inputs (0,3), (0,5), (0,7), (1,2) back-to-back -> out_valid one cycle after the 4th accept, out_acc=0x21, out_ovf=0.
- Overflow, wrap (ACC_W=8, N_SAMPLES=10): ten inputs of (1,15) -> out_acc=54 (310 mod 256), out_ovf=1. With NIBBLE_SUM_ACC_SAT_EN -> out_acc=255, out_ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 throughout, out_acc unchanged. Then out_ready=1 -> next frame starts from 0, first accept one cycle later.
- Clear: assert clear after 2 of 4 samples (acc=8), concurrent with in_valid -> acc=0, that input not summed. A new frame (1,1,1,1) gives out_acc=4.
- Async reset: assert rst mid-frame between clock edges -> outputs go to reset values immediately. After release, a fresh 4-sample frame sums correctly.
- Edge case N_SAMPLES=1: input (1,15) -> out_valid next cycle, out_acc=31. Alternating handshakes sustain one result every 2 cycles.
